// File: rtl/link_pkg.sv
// Shared definitions for the 4-phase link master: FSM states and counter-width helper.
package link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_REQ,
    ST_DROP,
    ST_DONE
  } link_state_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/link_fifo.sv
// Synchronous FIFO feeding the link master; power-of-2 depth, registered occupancy count.
module link_fifo
  import link_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = cnt_w(DEPTH - 1);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // Flags come from the pre-edge count, so a pop on an empty FIFO is refused even if a push lands.
  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    rdata    = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/hs4_link_master.sv
// Burst master: drains buffered words to a link slave, one full req/ack 4-phase handshake per word.
module hs4_link_master
  import link_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  input  logic                           start,
  output logic                           req,
  input  logic                           ack,
  output logic [DATA_W-1:0]              data,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout_err,
  output logic [$clog2(BURST_LEN+1)-1:0] sent_cnt
);

  localparam int                SENT_W    = $clog2(BURST_LEN + 1);
  localparam int                WAIT_W    = cnt_w(TIMEOUT - 1);
  localparam logic [SENT_W-1:0] SENT_LAST = SENT_W'(BURST_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam bit                TMO_EN    = (TIMEOUT != 0);

  link_state_e       state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              timeout_err_q, timeout_err_d;
  logic [SENT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              fifo_pop, fifo_full, fifo_empty, wait_expired;
  logic [DATA_W-1:0] fifo_rdata;

  link_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wait_expired = TMO_EN && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    data_d        = data_q;
    timeout_err_d = timeout_err_q;
    sent_cnt_d    = sent_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    fifo_pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sent_cnt_d    = '0;
          timeout_err_d = 1'b0;
          state_d       = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          data_d     = fifo_rdata;
          fifo_pop   = 1'b1;
          req_d      = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack) begin
          req_d      = 1'b0;
          wait_cnt_d = '0;
          state_d    = ST_DROP;
        end else if (wait_expired) begin
          req_d         = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DROP: begin
        if (!ack) begin
          sent_cnt_d = sent_cnt_q + 1'b1;
          state_d    = (sent_cnt_q == SENT_LAST) ? ST_DONE : ST_FETCH;
        end else if (wait_expired) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      req_q         <= 1'b0;
      data_q        <= '0;
      timeout_err_q <= 1'b0;
      sent_cnt_q    <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      data_q        <= data_d;
      timeout_err_q <= timeout_err_d;
      sent_cnt_q    <= sent_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign req         = req_q;
  assign data        = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign timeout_err = timeout_err_q;
  assign sent_cnt    = sent_cnt_q;

endmodule

// File: tb/tb_hs4_link_master.sv
// Scoreboard bench: expected link words are queued at push time and checked as the link presents them.
module tb_hs4_link_master;

  localparam int DEPTH = 4;
  localparam int BURST = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, start, req, busy, done, timeout_err;
  logic        ack = 1'b0;
  logic [7:0]  in_data, data;
  logic [2:0]  sent_cnt;
  logic        in_valid_b, in_ready_b, start_b, req_b, busy_b, done_b, timeout_err_b;
  logic        ack_b = 1'b0;
  logic [15:0] in_data_b, data_b;
  logic [1:0]  sent_cnt_b;

  int comp_cnt = 0, err_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] exp_b_q[$];
  int occ = 0;
  int done_cnt = 0, done_b_cnt = 0, rise_cnt = 0, rise_b_cnt = 0;
  bit never_ack = 1'b0;
  int sdly = 0;

  hs4_link_master u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .start(start), .req(req), .ack(ack), .data(data), .busy(busy), .done(done),
    .timeout_err(timeout_err), .sent_cnt(sent_cnt)
  );

  hs4_link_master #(.DATA_W(16), .DEPTH(4), .BURST_LEN(3), .TIMEOUT(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .start(start_b), .req(req_b), .ack(ack_b), .data(data_b), .busy(busy_b), .done(done_b),
    .timeout_err(timeout_err_b), .sent_cnt(sent_cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    comp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: ack follows req after sdly extra cycles; can be told never to ack.
  int scnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      ack = 1'b0; scnt = 0;
    end else if (!never_ack) begin
      if (req && !ack) begin
        if (scnt >= sdly) begin ack = 1'b1; scnt = 0; end else scnt++;
      end else if (!req && ack) begin
        if (scnt >= sdly) begin ack = 1'b0; scnt = 0; end else scnt++;
      end
    end
  end

  // Slave for the wide instance: acks one cycle after req, holds ack five cycles.
  int hold_b = 0;
  always @(negedge clk) begin
    if (!rst) begin
      ack_b = 1'b0; hold_b = 0;
    end else if (ack_b) begin
      if (hold_b < 5) hold_b++;
      else if (!req_b) begin ack_b = 1'b0; hold_b = 0; end
    end else if (req_b) begin
      ack_b = 1'b1; hold_b = 1;
    end
  end

  logic        req_prev = 1'b0, req_b_prev = 1'b0;
  logic [7:0]  cap;
  logic [15:0] cap_b;
  always @(negedge clk) begin
    if (!rst) begin
      req_prev = 1'b0;
    end else begin
      if (req && !req_prev) begin
        occ--; rise_cnt++;
        if (exp_q.size() == 0) begin
          comp_cnt++; err_cnt++;
          $display("FAIL link_word: got %0h while no word was expected", data);
        end else check("link_word", data, exp_q.pop_front());
        cap = data;
      end else if (req) check("data_stable", data, cap);
      req_prev = req;
    end
    if (done) done_cnt++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      req_b_prev = 1'b0;
    end else begin
      if (req_b && !req_b_prev) begin
        rise_b_cnt++;
        if (exp_b_q.size() == 0) begin
          comp_cnt++; err_cnt++;
          $display("FAIL link_word_b: got %0h while no word was expected", data_b);
        end else check("link_word_b", data_b, exp_b_q.pop_front());
        cap_b = data_b;
      end else if (req_b || ack_b) check("data_stable_b", data_b, cap_b);
      req_b_prev = req_b;
    end
    if (done_b) done_b_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d);
    bit acc;
    acc = (occ < DEPTH);
    in_valid = 1'b1; in_data = d;
    check("in_ready", in_ready, acc);
    tick();
    in_valid = 1'b0;
    if (acc) begin occ++; exp_q.push_back(d); end
  endtask

  task automatic push_b(input logic [15:0] d);
    in_valid_b = 1'b1; in_data_b = d;
    check("in_ready_b", in_ready_b, 1);
    tick();
    in_valid_b = 1'b0;
    exp_b_q.push_back(d);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    repeat (3) tick();
    check("done_pulses", done_cnt - d0, 1);
    check("sent_cnt", sent_cnt, BURST);
    check("timeout_err_clear", timeout_err, 0);
    check("busy_after_done", busy, 0);
    check("words_left", exp_q.size(), 0);
  endtask

  task automatic wait_req(input logic lvl, input int budget, output int n);
    n = 0;
    while (req !== lvl && n < budget) begin tick(); n++; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, n, r0;
    bit stall_bad;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; start = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; start_b = 1'b0;
    repeat (2) tick();
    check("rst_req", req, 0);       check("rst_data", data, 0);
    check("rst_busy", busy, 0);     check("rst_done", done, 0);
    check("rst_tmo", timeout_err, 0); check("rst_sent", sent_cnt, 0);
    check("rst_ready", in_ready, 1); check("rst_req_b", req_b, 0);
    rst = 1'b1; tick();

    // Basic burst and start-to-req latency
    d0 = done_cnt;
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    pulse_start();
    check("lat_fetch_req", req, 0);
    tick();
    check("lat_req", req, 1);
    wait_done(d0, 100);

    // Wide instance, long ack hold, ignored mid-burst start
    d0 = done_b_cnt;
    push_b(16'h1234); push_b(16'hBEEF); push_b(16'h0001);
    start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0;
    while (rise_b_cnt < 2 && n < 100) begin tick(); n++; end
    check("b_second_word", rise_b_cnt, 2);
    start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0;
    while (done_b_cnt == d0 && n < 200) begin tick(); n++; end
    repeat (3) tick();
    check("b_done_pulses", done_b_cnt - d0, 1);
    check("b_sent_cnt", sent_cnt_b, 3);
    check("b_busy", busy_b, 0);
    check("b_tmo", timeout_err_b, 0);
    check("b_words_left", exp_b_q.size(), 0);

    // Ack timeout
    never_ack = 1'b1;
    d0 = done_cnt;
    push(8'($urandom));
    pulse_start();
    wait_req(1'b1, 10, n);
    check("tmo_req_rise", req, 1);
    wait_req(1'b0, 40, n);
    check("tmo_req_cycles", n, TMO);
    check("tmo_err", timeout_err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_sent", sent_cnt, 0);
    repeat (3) tick();
    check("tmo_no_done", done_cnt - d0, 0);
    never_ack = 1'b0;
    for (int i = 0; i < BURST; i++) push(8'($urandom));
    d0 = done_cnt;
    pulse_start();
    check("tmo_cleared", timeout_err, 0);
    wait_done(d0, 100);

    // Start with empty FIFO: stall without timeout
    d0 = done_cnt;
    pulse_start();
    stall_bad = 1'b0;
    repeat (20) begin tick(); if (req !== 1'b0) stall_bad = 1'b1; end
    check("stall_req_low", stall_bad, 0);
    check("stall_busy", busy, 1);
    check("stall_tmo", timeout_err, 0);
    push(8'h55);
    check("stall_push_req0", req, 0);
    tick();
    check("stall_push_req1", req, 1);
    for (int i = 1; i < BURST; i++) push(8'($urandom));
    wait_done(d0, 100);

    // Overfill: six words offered, four stored
    for (int i = 1; i <= 6; i++) push(8'(i * 17));
    d0 = done_cnt;
    pulse_start();
    wait_done(d0, 100);

    // Randomised bursts
    for (int it = 0; it < 20; it++) begin
      int nw;
      nw = $urandom_range(4, 6);
      for (int i = 0; i < nw; i++) begin
        push(8'($urandom));
        repeat ($urandom_range(0, 2)) tick();
      end
      sdly = $urandom_range(0, 3);
      d0 = done_cnt;
      pulse_start();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(3, 8)) tick();
        pulse_start();
      end
      wait_done(d0, 200);
    end

    // Reset during second word
    sdly = 3;
    for (int i = 0; i < BURST; i++) push(8'($urandom));
    r0 = rise_cnt;
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (rise_cnt < r0 + 2 && n < 60) begin tick(); n++; end
    check("rst_mid_second", rise_cnt - r0, 2);
    check("rst_mid_req_hi", req, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_req", req, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_done", done, 0);
    exp_q.delete(); occ = 0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    check("rst_rel_busy", busy, 0);
    check("rst_rel_no_done", done_cnt - d0, 0);
    pulse_start();
    stall_bad = 1'b0;
    repeat (8) begin tick(); if (req !== 1'b0) stall_bad = 1'b1; end
    check("rst_fifo_empty", stall_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, err_cnt);
    $finish;
  end

endmodule
